// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO: buffers {pc, pc+4, instr} from fetch and presents the oldest entry to decode.
// Optional IF_ID_QUEUE_PERF_EN builds the decode-stall and flush cycle counters; otherwise both read 0.
module if_id_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        enq_valid,
  output logic        enq_ready,
  input  logic [31:0] enq_pc,
  input  logic [31:0] enq_pc_plus_4,
  input  logic [31:0] enq_instr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus_4,
  output logic [31:0] id_instr,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     count;
  logic            enq_fire, deq_fire;
  entry_t          head;

  // enq_ready looks only at registered count, never at id_ready, so fetch has no path into decode
  assign enq_ready = (count != CNT_FULL) && !flush;
  assign id_valid  = (count != '0);
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = id_valid && id_ready && !flush;

  assign head         = mem[rd_ptr];
  assign id_pc        = id_valid ? head.pc        : 32'h0;
  assign id_pc_plus_4 = id_valid ? head.pc_plus_4 : 32'h0;
  assign id_instr     = id_valid ? head.instr     : NOP_INSTR;

  // Payload is never reset; outputs above are masked by id_valid
  always_ff @(posedge clk) begin
    if (enq_fire) mem[wr_ptr] <= '{pc: enq_pc, pc_plus_4: enq_pc_plus_4, instr: enq_instr};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0] stall_cnt_r, flush_cnt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (id_valid && !id_ready && !flush) stall_cnt_r <= stall_cnt_r + 32'd1;
      if (flush)                           flush_cnt_r <= flush_cnt_r + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=2); counter checks follow IF_ID_QUEUE_PERF_EN.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst, flush, enq_valid, enq_ready, id_valid, id_ready;
  logic [31:0] enq_pc, enq_pc_plus_4, enq_instr;
  logic [31:0] id_pc, id_pc_plus_4, id_instr, stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(2), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_pc_plus_4(enq_pc_plus_4), .enq_instr(enq_instr),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4), .id_instr(id_instr),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    enq_valid     = v;
    enq_pc        = pc;
    enq_pc_plus_4 = pc + 32'd4;
    enq_instr     = instr;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, "_valid"}, 32'(id_valid), 32'd1);
    chk({tag, "_pc"},    id_pc,         pc);
    chk({tag, "_pc4"},   id_pc_plus_4,  pc + 32'd4);
    chk({tag, "_instr"}, id_instr,      instr);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_instr"}, id_instr,      32'h00000013);
    chk({tag, "_pc"},    id_pc,         32'h0);
    chk({tag, "_pc4"},   id_pc_plus_4,  32'h0);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] st, input logic [31:0] fl);
`ifdef IF_ID_QUEUE_PERF_EN
    chk({tag, "_stall"}, stall_cnt, st);
    chk({tag, "_flush"}, flush_cnt, fl);
`else
    chk({tag, "_stall"}, stall_cnt, 32'h0);
    chk({tag, "_flush"}, flush_cnt, 32'h0);
    if (st == 32'hFFFF_FFFF || fl == 32'hFFFF_FFFF) $display("unexpected counter tag %s", tag);
`endif
  endtask

  initial begin
    int sent, rcvd, cyc;
    logic acc, deq;

    rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk_empty("reset");
    chk_cnt("reset", 32'd0, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_enq_ready", 32'(enq_ready), 32'd1);

    // Stream two words with decode always ready
    id_ready = 1'b1;
    offer(1'b1, 32'h0, 32'h00500093);
    tick();
    chk_head("s0", 32'h0, 32'h00500093);
    offer(1'b1, 32'h4, 32'h00A00113);
    tick();
    chk_head("s1", 32'h4, 32'h00A00113);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk_empty("s_end");

    // Fill with decode stalled; third word refused
    id_ready = 1'b0;
    offer(1'b1, 32'h0, 32'hA0000000);
    tick();
    chk("f1_ready", 32'(enq_ready), 32'd1);
    offer(1'b1, 32'h4, 32'hA0000004);
    tick();
    chk("f2_ready", 32'(enq_ready), 32'd0);
    offer(1'b1, 32'h8, 32'hA0000008);
    tick();
    chk_head("f3", 32'h0, 32'hA0000000);
    chk_cnt("f3", 32'd2, 32'd0);

    // Full with dequeue: pop happens, push waits a cycle, order kept
    id_ready = 1'b1;
    #1;
    chk("fd_ready", 32'(enq_ready), 32'd0);
    tick();
    chk_head("fd1", 32'h4, 32'hA0000004);
    tick();
    chk_head("fd2", 32'h8, 32'hA0000008);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk_empty("fd_end");

    // Flush with simultaneous enqueue and dequeue
    id_ready = 1'b0;
    offer(1'b1, 32'h40, 32'hB0000040);
    tick();
    offer(1'b1, 32'h44, 32'hB0000044);
    tick();
    flush = 1'b1; id_ready = 1'b1;
    offer(1'b1, 32'h48, 32'hB0000048);
    #1;
    chk("fl_enq_ready", 32'(enq_ready), 32'd0);
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    chk_empty("fl");
    chk_cnt("fl", 32'd3, 32'd1);
    id_ready = 1'b0;
    offer(1'b1, 32'h100, 32'hC0000100);
    tick();
    chk_head("fl_new", 32'h100, 32'hC0000100);
    offer(1'b0, 32'h0, 32'h0);
    id_ready = 1'b1;
    tick();
    chk_empty("fl_end");
    chk_cnt("fl_end", 32'd3, 32'd1);

    // Pointer wrap: 10 words, random decode readiness
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 10 && cyc < 200) begin
      offer(sent < 10, 32'(4 * sent), 32'hD0000000 + 32'(4 * sent));
      id_ready = 1'($urandom_range(0, 1));
      #1;
      acc = enq_valid && enq_ready;
      deq = id_valid && id_ready;
      if (deq) begin
        chk("wrap_pc",    id_pc,    32'(4 * rcvd));
        chk("wrap_instr", id_instr, 32'hD0000000 + 32'(4 * rcvd));
        rcvd++;
      end
      if (acc) sent++;
      tick();
      cyc++;
    end
    offer(1'b0, 32'h0, 32'h0);
    chk("wrap_rcvd", 32'(rcvd), 32'd10);
    chk("wrap_empty", 32'(id_valid), 32'd0);

    // Flush counter wrap
`ifdef IF_ID_QUEUE_PERF_EN
    force dut.flush_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.flush_cnt_r;
    chk("wrap_fcnt_pre", flush_cnt, 32'hFFFF_FFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("wrap_fcnt_post", flush_cnt, 32'h0);
`else
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_cnt("noperf", 32'd0, 32'd0);
`endif

    // Reset mid-operation clears entries and counters
    id_ready = 1'b0;
    offer(1'b1, 32'h200, 32'hE0000200);
    tick();
    tick();
    offer(1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_empty("mid_rst");
    chk_cnt("mid_rst", 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
